tensor_b_feeder: RTL and testbench
==================================

Name: tensor_b_feeder

Overview:
- Transmit side of the thread-group B-operand interface in the tensor unit.
- Accepts B-tile rows from the operand load path, holds up to NUM_TILE_BUFS complete tiles, and streams each tile row by row to every thread group's B_data_in bus.
- A ready/valid handshake throttles the stream. A one-cycle wb_tile_buf strobe marks each tile fully delivered.

Parameters:
- NUM_THREAD_GROUPS, 4, number of thread groups fed in parallel
- THREAD_GROUP_SIZE, 4, lanes per thread group
- XLEN, 32, bits per lane element
- TILE_K, 4, rows per B tile (power of two, >=2)
- NUM_TILE_BUFS, 2, complete tiles buffered (>=1)
- Derived: ROW_W = NUM_THREAD_GROUPS*THREAD_GROUP_SIZE*XLEN

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all buffered and partial tiles
- in_valid  in  1  a row is offered
- in_ready  out  1  feeder accepts the row this cycle
- in_data  in  ROW_W  one B row; group g lane l at bits [(g*THREAD_GROUP_SIZE+l)*XLEN +: XLEN]
- in_fmt  in  1  element format of the tile; sampled on the tile's row 0 only
- out_valid  out  1  a row is presented to the groups
- out_ready  in  1  AND of all groups' accept, formed outside this block
- out_data  out  ROW_W  row fanned out to B_data_in of all groups
- out_row  out  $clog2(TILE_K)  index of the presented row
- out_last  out  1  presented row is row TILE_K-1
- out_fmt  out  1  format stored with the presented tile
- wb_tile_buf  out  1  one-cycle strobe after a tile's last row is accepted
- tiles_pending  out  $clog2(NUM_TILE_BUFS+1)  committed tiles not yet fully sent

Behaviour:
- Reset (async, active-high):
  - All pointers, counters and the row index clear to 0.
  - in_ready=1, out_valid=0, out_row=0, out_last=0, out_fmt=0, wb_tile_buf=0, tiles_pending=0.
  - out_data=0. Storage contents are don't-care.
- Storage: NUM_TILE_BUFS x TILE_K rows of ROW_W bits, plus one fmt bit per tile slot.
- Write side:
  - Write slot pointer wslot and row counter wrow.
  - in_ready = (tiles_pending < NUM_TILE_BUFS).
  - Handshake (in_valid & in_ready) writes in_data to [wslot][wrow].
  - If wrow==0, also latch in_fmt into fmt[wslot].
  - wrow increments on each handshake. When wrow==TILE_K-1 the tile commits: wrow returns to 0, wslot advances modulo NUM_TILE_BUFS, tiles_pending increments.
  - in_ready drops in the cycle after the commit that fills the last slot.
- Read side:
  - Read slot pointer rslot and row counter rrow.
  - out_valid = (tiles_pending != 0).
  - out_data = storage[rslot][rrow]; out_row = rrow; out_last = (rrow==TILE_K-1); out_fmt = fmt[rslot]. All are combinational from registered pointers.
  - Handshake (out_valid & out_ready) increments rrow.
  - On the handshake with out_last=1: rrow returns to 0, rslot advances modulo NUM_TILE_BUFS, tiles_pending decrements, wb_tile_buf registered high for exactly the next cycle.
- Latency:
  - A tile committed at edge N shows out_valid=1 in cycle N+1 (row 0).
  - Rows then flow one per cycle while out_ready=1.
- Hold: while out_valid=1 and out_ready=0, out_data, out_row, out_last and out_fmt are held stable.
- Simultaneous commit and release in one cycle: tiles_pending unchanged, both pointers advance.
- A partial tile (wrow!=0) is never visible on the output side.
- Wrap-around: both slot pointers wrap from NUM_TILE_BUFS-1 to 0.
- Full:
  - In-flight write rows are accepted only while a slot is free.
  - A release in the full state raises in_ready in the next cycle, not combinationally.
- Flush:
  - Clears wslot, wrow, rslot, rrow and tiles_pending at the next edge and discards the partial tile.
  - Overrides any same-cycle handshake on either side; no wb_tile_buf is generated for flushed tiles.
- Reset mid-stream: identical effect to flush, but asynchronous.

Decomposition:
- Shared tensor package: XLEN, THREAD_GROUP_SIZE, NUM_THREAD_GROUPS, TILE_K, and a b_row_t packed type of [NUM_THREAD_GROUPS][THREAD_GROUP_SIZE][XLEN-1:0] used by both feeder and thread_group.
- One natural sub-module: tensor_tile_store. It holds the slot/row-addressed storage array with one write port and one combinational read port. Pointer, count and strobe control stays in tensor_b_feeder.

Test Plan:
- Single tile: push rows 0xA0..0xA3 (replicated per lane), in_fmt=1 on row 0, out_ready=1.
  - Required: out_valid rises one cycle after the commit; rows appear in order with out_row 0..3 and out_last only on row 3; out_fmt=1.
  - wb_tile_buf pulses once, one cycle after row 3 is accepted; tiles_pending returns to 0.
- Full: push 2 tiles with out_ready=0.
  - Required: tiles_pending=2 and in_ready=0; a 9th row is held off.
  - Raising out_ready drains tile 0 then tile 1, each with its own fmt bit.
- Back-pressure: toggle out_ready 1,0,0,1 mid-tile.
  - Required: out_data and out_row stay stable during the stalls; no row is dropped or duplicated.
- Simultaneous commit and release: tiles_pending=1; the last write row and the last read row handshake in the same cycle.
  - Required: tiles_pending stays 1, wb_tile_buf pulses, and the next tile streams from row 0 of the other slot.
- Flush: flush after 2 of 4 rows of tile 1 while tile 0 is at out_row=2.
  - Required: next cycle out_valid=0, tiles_pending=0, no wb_tile_buf.
  - A fresh tile then streams from slot 0, row 0.
- Async reset asserted mid-row: all outputs reach their reset values before the next clk edge; normal operation resumes after deassertion.

Source files
------------

// File: rtl/tensor_b_feeder_pkg.sv
// Shared tensor-unit definitions: lane geometry, tile geometry and the B-row type
// that the B feeder and the thread groups agree on.
package tensor_b_feeder_pkg;

  localparam int XLEN              = 32;
  localparam int THREAD_GROUP_SIZE = 4;
  localparam int NUM_THREAD_GROUPS = 4;
  localparam int TILE_K            = 4;
  localparam int NUM_TILE_BUFS     = 2;

  localparam int ROW_W     = NUM_THREAD_GROUPS * THREAD_GROUP_SIZE * XLEN;
  localparam int ROW_IDX_W = $clog2(TILE_K);
  localparam int SLOT_W    = (NUM_TILE_BUFS > 1) ? $clog2(NUM_TILE_BUFS) : 1;
  localparam int CNT_W     = $clog2(NUM_TILE_BUFS + 1);

  // Group g lane l lands at bits [(g*THREAD_GROUP_SIZE+l)*XLEN +: XLEN]
  typedef logic [NUM_THREAD_GROUPS-1:0][THREAD_GROUP_SIZE-1:0][XLEN-1:0] b_row_t;

  typedef logic [ROW_IDX_W-1:0] row_idx_t;
  typedef logic [SLOT_W-1:0]    slot_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  // Slot pointers wrap from the last buffer back to 0, also for non-power-of-two counts
  function automatic slot_t nextSlot(input slot_t s);
    return (s == slot_t'(NUM_TILE_BUFS - 1)) ? '0 : s + slot_t'(1);
  endfunction

endpackage

// File: rtl/tensor_b_feeder_if.sv
// B-operand stream bundle: row intake from the operand load path on one side,
// the row broadcast towards the thread groups on the other.
interface tensor_b_feeder_if;
  import tensor_b_feeder_pkg::*;

  logic     in_valid;
  logic     in_ready;
  b_row_t   in_data;
  logic     in_fmt;
  logic     out_valid;
  logic     out_ready;
  b_row_t   out_data;
  row_idx_t out_row;
  logic     out_last;
  logic     out_fmt;
  logic     wb_tile_buf;
  cnt_t     tiles_pending;

  // Feeder side
  modport master (
    input  in_valid, in_data, in_fmt, out_ready,
    output in_ready, out_valid, out_data, out_row, out_last, out_fmt,
           wb_tile_buf, tiles_pending
  );

  // Environment side: load path plus thread-group acceptance
  modport slave (
    output in_valid, in_data, in_fmt, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_last, out_fmt,
           wb_tile_buf, tiles_pending
  );

endinterface

// File: rtl/tensor_tile_store.sv
// Slot/row addressed B-tile storage: one synchronous write port and one
// combinational read port, plus a format bit per tile slot.
module tensor_tile_store
  import tensor_b_feeder_pkg::*;
(
  input  logic     clk,
  input  logic     i_we,
  input  slot_t    i_wslot,
  input  row_idx_t i_wrow,
  input  b_row_t   i_wdata,
  input  logic     i_wfmt_en,
  input  logic     i_wfmt,
  input  slot_t    i_rslot,
  input  row_idx_t i_rrow,
  output b_row_t   o_rdata,
  output logic     o_rfmt
);

  b_row_t r_mem [NUM_TILE_BUFS][TILE_K];
  logic   r_fmt [NUM_TILE_BUFS];

  // Row write; the tile format is captured alongside row 0 only
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wslot][i_wrow] <= i_wdata;
      if (i_wfmt_en) begin
        r_fmt[i_wslot] <= i_wfmt;
      end
    end
  end

  assign o_rdata = r_mem[i_rslot][i_rrow];
  assign o_rfmt  = r_fmt[i_rslot];

endmodule

// File: rtl/tensor_b_feeder.sv
// B-operand transmit side: buffers complete B tiles and streams them row by row
// to all thread groups, with a one-cycle strobe per fully delivered tile.
module tensor_b_feeder
  import tensor_b_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  tensor_b_feeder_if.master bus
);

  localparam cnt_t     BUFS_C   = cnt_t'(NUM_TILE_BUFS);
  localparam row_idx_t LAST_ROW = row_idx_t'(TILE_K - 1);

  slot_t    r_wslot;
  slot_t    r_rslot;
  row_idx_t r_wrow;
  row_idx_t r_rrow;
  cnt_t     r_pending;
  logic     r_wb;

  logic     w_in_ready;
  logic     w_out_valid;
  logic     w_in_fire;
  logic     w_out_fire;
  logic     w_commit;
  logic     w_release;
  b_row_t   w_rdata;
  logic     w_rfmt;

  // Ready and valid come only from the registered tile count, so a release in
  // the full state reopens the intake one cycle later
  assign w_in_ready  = (r_pending < BUFS_C);
  assign w_out_valid = (r_pending != '0);
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;
  assign w_commit    = w_in_fire & (r_wrow == LAST_ROW);
  assign w_release   = w_out_fire & (r_rrow == LAST_ROW);

  tensor_tile_store u_store (
    .clk       (clk),
    .i_we      (w_in_fire & ~flush),
    .i_wslot   (r_wslot),
    .i_wrow    (r_wrow),
    .i_wdata   (bus.in_data),
    .i_wfmt_en (r_wrow == '0),
    .i_wfmt    (bus.in_fmt),
    .i_rslot   (r_rslot),
    .i_rrow    (r_rrow),
    .o_rdata   (w_rdata),
    .o_rfmt    (w_rfmt)
  );

  // Pointer, tile count and delivery strobe update; flush wins over both handshakes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wslot   <= '0;
      r_rslot   <= '0;
      r_wrow    <= '0;
      r_rrow    <= '0;
      r_pending <= '0;
      r_wb      <= 1'b0;
    end else if (flush) begin
      r_wslot   <= '0;
      r_rslot   <= '0;
      r_wrow    <= '0;
      r_rrow    <= '0;
      r_pending <= '0;
      r_wb      <= 1'b0;
    end else begin
      r_wb <= w_release;
      if (w_in_fire) begin
        if (w_commit) begin
          r_wrow  <= '0;
          r_wslot <= nextSlot(r_wslot);
        end else begin
          r_wrow <= r_wrow + row_idx_t'(1);
        end
      end
      if (w_out_fire) begin
        if (w_release) begin
          r_rrow  <= '0;
          r_rslot <= nextSlot(r_rslot);
        end else begin
          r_rrow <= r_rrow + row_idx_t'(1);
        end
      end
      case ({w_commit, w_release})
        2'b10:   r_pending <= r_pending + cnt_t'(1);
        2'b01:   r_pending <= r_pending - cnt_t'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Data and format are zeroed while nothing is presented so stale storage never leaks out
  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_data      = w_out_valid ? w_rdata : '0;
  assign bus.out_fmt       = w_out_valid & w_rfmt;
  assign bus.out_row       = r_rrow;
  assign bus.out_last      = (r_rrow == LAST_ROW);
  assign bus.wb_tile_buf   = r_wb;
  assign bus.tiles_pending = r_pending;

endmodule

// File: tb/tb_tensor_b_feeder.sv
// Self-checking bench for tensor_b_feeder: directed scenarios followed by a
// randomized phase, all checked against a queue-based tile model.
module tb_tensor_b_feeder;
  import tensor_b_feeder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  tensor_b_feeder_if busIf ();

  tensor_b_feeder dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (busIf)
  );

  always #5 clk = ~clk;

  // Reference model: committed rows in arrival order, one fmt per committed tile,
  // the tile being assembled, and the row index within the head tile
  b_row_t mRows[$];
  logic   mFmts[$];
  b_row_t mPart[$];
  logic   mPartFmt;
  int     mRd;
  logic   expWb;

  int nAsserts = 0;
  int nFail    = 0;

  function automatic b_row_t repRow(input int v);
    b_row_t r;
    for (int g = 0; g < NUM_THREAD_GROUPS; g++)
      for (int l = 0; l < THREAD_GROUP_SIZE; l++)
        r[g][l] = XLEN'(v);
    return r;
  endfunction

  function automatic b_row_t randRow();
    b_row_t r;
    for (int g = 0; g < NUM_THREAD_GROUPS; g++)
      for (int l = 0; l < THREAD_GROUP_SIZE; l++)
        r[g][l] = XLEN'($urandom);
    return r;
  endfunction

  task automatic chkBit(input string tag, input logic obs, input logic req);
    nAsserts++;
    assert (obs === req) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0b, required %0b", tag, obs, req);
    end
  endtask

  task automatic chkNum(input string tag, input int obs, input int req);
    nAsserts++;
    assert (obs === req) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d, required %0d", tag, obs, req);
    end
  endtask

  task automatic chkRow(input string tag, input b_row_t obs, input b_row_t req);
    nAsserts++;
    assert (obs === req) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h, required %0h", tag, obs, req);
    end
  endtask

  task automatic modelClear();
    mRows.delete();
    mFmts.delete();
    mPart.delete();
    mPartFmt = 1'b0;
    mRd      = 0;
    expWb    = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs held during the cycle
  task automatic modelUpdate(input logic iv, input b_row_t d, input logic f,
                             input logic ordy, input logic fl);
    int   n       = mFmts.size();
    logic inFire  = iv && (n < NUM_TILE_BUFS);
    logic outFire = ordy && (n != 0);
    logic rel     = outFire && (mRd == TILE_K - 1);
    if (fl) begin
      modelClear();
      return;
    end
    if (outFire) begin
      if (rel) begin
        for (int i = 0; i < TILE_K; i++) void'(mRows.pop_front());
        void'(mFmts.pop_front());
        mRd = 0;
      end else begin
        mRd++;
      end
    end
    if (inFire) begin
      if (mPart.size() == 0) mPartFmt = f;
      mPart.push_back(d);
      if (mPart.size() == TILE_K) begin
        for (int i = 0; i < TILE_K; i++) mRows.push_back(mPart[i]);
        mFmts.push_back(mPartFmt);
        mPart.delete();
      end
    end
    expWb = rel;
  endtask

  task automatic applyStimulus(input logic iv, input b_row_t d, input logic f,
                               input logic ordy, input logic fl);
    busIf.in_valid  = iv;
    busIf.in_data   = d;
    busIf.in_fmt    = f;
    busIf.out_ready = ordy;
    flush           = fl;
  endtask

  task automatic checkOutput();
    int n = mFmts.size();
    chkBit("in_ready", busIf.in_ready, n < NUM_TILE_BUFS);
    chkBit("out_valid", busIf.out_valid, n != 0);
    chkNum("tiles_pending", int'(busIf.tiles_pending), n);
    chkBit("wb_tile_buf", busIf.wb_tile_buf, expWb);
    chkNum("out_row", int'(busIf.out_row), mRd);
    chkBit("out_last", busIf.out_last, mRd == TILE_K - 1);
    if (n != 0) begin
      chkRow("out_data", busIf.out_data, mRows[mRd]);
      chkBit("out_fmt", busIf.out_fmt, mFmts[0]);
    end
  endtask

  task automatic checkResetValues();
    checkOutput();
    chkRow("reset out_data", busIf.out_data, '0);
    chkBit("reset out_fmt", busIf.out_fmt, 1'b0);
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, advance model and DUT
  task automatic step(input logic iv, input b_row_t d, input logic f,
                      input logic ordy, input logic fl);
    applyStimulus(iv, d, f, ordy, fl);
    #2;
    checkOutput();
    modelUpdate(iv, d, f, ordy, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles, input logic ordy);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b0, ordy, 1'b0);
  endtask

  task automatic pushRandTile(input logic ordy);
    for (int i = 0; i < TILE_K; i++) step(1'b1, randRow(), 1'(($urandom % 2)), ordy, 1'b0);
  endtask

  initial begin
    logic [3:0] bpPattern;

    modelClear();
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    $display("[TB] Checking reset state");
    checkResetValues();
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] Single tile");
    for (int i = 0; i < TILE_K; i++) step(1'b1, repRow(32'hA0 + i), (i == 0), 1'b1, 1'b0);
    idle(6, 1'b1);

    $display("[TB] Full buffers and drain");
    for (int i = 0; i < 10; i++) step(1'b1, randRow(), 1'(($urandom % 2)), 1'b0, 1'b0);
    chkNum("full tiles_pending", int'(busIf.tiles_pending), NUM_TILE_BUFS);
    chkBit("full in_ready", busIf.in_ready, 1'b0);
    idle(12, 1'b1);

    $display("[TB] Back-pressure mid-tile");
    pushRandTile(1'b0);
    bpPattern = 4'b1001;
    for (int i = 3; i >= 0; i--) step(1'b0, '0, 1'b0, bpPattern[i], 1'b0);
    idle(6, 1'b1);

    $display("[TB] Simultaneous commit and release");
    pushRandTile(1'b0);
    pushRandTile(1'b1);
    idle(6, 1'b1);

    $display("[TB] Flush mid-stream");
    pushRandTile(1'b0);
    step(1'b1, randRow(), 1'b1, 1'b1, 1'b0);
    step(1'b1, randRow(), 1'b0, 1'b1, 1'b0);
    step(1'b1, randRow(), 1'b0, 1'b1, 1'b1);
    pushRandTile(1'b1);
    idle(6, 1'b1);

    $display("[TB] Asynchronous reset mid-row");
    pushRandTile(1'b0);
    step(1'b1, randRow(), 1'b1, 1'b1, 1'b0);
    step(1'b1, randRow(), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    reset = 1'b1;
    modelClear();
    #1;
    checkResetValues();
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    pushRandTile(1'b1);
    idle(6, 1'b1);

    $display("[TB] Randomized traffic");
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, randRow(), 1'(($urandom % 2)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    idle(12, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
